// File: rtl/rx_alu_pkg.sv
// Shared definitions for the RX operand collector and its ALU:
// default widths, opcode values and the collector state encoding.
package rx_alu_pkg;

  localparam int unsigned NB_DATA_DEF     = 8;
  localparam int unsigned NB_OPERADOR_DEF = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_alu_exec.sv
// Purely combinational ALU: signed operands, result truncated to NB_DATA,
// unknown opcodes yield zero.
module rx_alu_exec
  import rx_alu_pkg::*;
#(
  parameter int unsigned NB_DATA     = NB_DATA_DEF,
  parameter int unsigned NB_OPERADOR = NB_OPERADOR_DEF
) (
  input  logic signed [NB_DATA-1:0]     a,
  input  logic signed [NB_DATA-1:0]     b,
  input  logic        [NB_OPERADOR-1:0] op,
  output logic signed [NB_DATA-1:0]     result
);

  always_comb begin
    result = '0;
    case (op)
      NB_OPERADOR'(OP_ADD): result = a + b;
      NB_OPERADOR'(OP_SUB): result = a - b;
      NB_OPERADOR'(OP_AND): result = a & b;
      NB_OPERADOR'(OP_OR):  result = a | b;
      NB_OPERADOR'(OP_XOR): result = a ^ b;
      NB_OPERADOR'(OP_NOR): result = ~(a | b);
      // b is the shift amount as an unsigned value; large amounts saturate to sign-fill / zero
      NB_OPERADOR'(OP_SRA): result = a >>> $unsigned(b);
      NB_OPERADOR'(OP_SRL): result = a >> $unsigned(b);
      default:              result = '0;
    endcase
  end

endmodule

// File: rtl/rx_alu_core.sv
// Byte-serial A/B/opcode collector feeding rx_alu_exec.
// Optional macro RX_ALU_OUT_REG_EN registers the result and delays the TX done pulse by one cycle.
module rx_alu_core
  import rx_alu_pkg::*;
#(
  parameter int unsigned NB_DATA     = NB_DATA_DEF,
  parameter int unsigned NB_OPERADOR = NB_OPERADOR_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic        [NB_DATA-1:0]     i_data,
  input  logic                          i_done_data,
  output logic signed [NB_DATA-1:0]     o_a,
  output logic signed [NB_DATA-1:0]     o_b,
  output logic        [NB_OPERADOR-1:0] o_op,
  output logic                          o_rx_alu_done,
  output logic signed [NB_DATA-1:0]     o_resultado,
  output logic                          o_done_alu_tx
);

  rx_state_e state, state_next;
  logic      done_prev;
  logic      accept;
  logic      load_a, load_b, load_op;
  logic signed [NB_DATA-1:0] alu_result;

  // A strobe held high for several cycles still counts as a single byte.
  assign accept = i_done_data & ~done_prev;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      done_prev <= 1'b0;
    end else begin
      done_prev <= i_done_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= WAIT_A;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_A:  if (accept) state_next = WAIT_B;
      WAIT_B:  if (accept) state_next = WAIT_OP;
      WAIT_OP: if (accept) state_next = WAIT_A;
      default: state_next = WAIT_A;
    endcase
  end

  always_comb begin
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_op = 1'b0;
    case (state)
      WAIT_A:  load_a  = accept;
      WAIT_B:  load_b  = accept;
      WAIT_OP: load_op = accept;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_a           <= '0;
      o_b           <= '0;
      o_op          <= '0;
      o_rx_alu_done <= 1'b0;
    end else begin
      if (load_a) o_a <= i_data;
      if (load_b) o_b <= i_data;
      if (load_op) o_op <= i_data[NB_OPERADOR-1:0];
      o_rx_alu_done <= load_op;
    end
  end

  rx_alu_exec #(
    .NB_DATA     (NB_DATA),
    .NB_OPERADOR (NB_OPERADOR)
  ) u_exec (
    .a      (o_a),
    .b      (o_b),
    .op     (o_op),
    .result (alu_result)
  );

`ifdef RX_ALU_OUT_REG_EN
  logic signed [NB_DATA-1:0] result_q;
  logic                      done_tx_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      result_q  <= '0;
      done_tx_q <= 1'b0;
    end else begin
      if (o_rx_alu_done) result_q <= alu_result;
      done_tx_q <= o_rx_alu_done;
    end
  end

  assign o_resultado   = result_q;
  assign o_done_alu_tx = done_tx_q;
`else
  assign o_resultado   = alu_result;
  assign o_done_alu_tx = o_rx_alu_done;
`endif

endmodule

// File: tb/tb_rx_alu_core.sv
// Self-checking bench for rx_alu_core: directed and randomized frames against a behavioural ALU model.
module tb_rx_alu_core;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic [7:0]        i_data = '0;
  logic              i_done_data = 1'b0;
  logic signed [7:0] o_a, o_b, o_resultado;
  logic [5:0]        o_op;
  logic              o_rx_alu_done, o_done_alu_tx;

  int checks = 0;
  int failures = 0;

`ifdef RX_ALU_OUT_REG_EN
  localparam int TX_LAT = 1;
`else
  localparam int TX_LAT = 0;
`endif

  rx_alu_core #(.NB_DATA(8), .NB_OPERADOR(6)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_data        (i_data),
    .i_done_data   (i_done_data),
    .o_a           (o_a),
    .o_b           (o_b),
    .o_op          (o_op),
    .o_rx_alu_done (o_rx_alu_done),
    .o_resultado   (o_resultado),
    .o_done_alu_tx (o_done_alu_tx)
  );

  always #5 i_clk = ~i_clk;

  int         cyc = 0;
  int         rx_pulses = 0;
  int         tx_pulses = 0;
  int         last_rx_cyc = 0;
  int         last_tx_cyc = 0;
  logic [7:0] last_res = '0;

  always @(negedge i_clk) begin
    cyc = cyc + 1;
    if (o_rx_alu_done === 1'b1) begin
      rx_pulses   = rx_pulses + 1;
      last_rx_cyc = cyc;
    end
    if (o_done_alu_tx === 1'b1) begin
      tx_pulses   = tx_pulses + 1;
      last_tx_cyc = cyc;
      last_res    = o_resultado;
    end
  end

  // Reference ALU from plain integer arithmetic on the opcode table.
  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    int sa, sb, ua, ub, d, m, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    r  = 0;
    case (op)
      6'h20: r = sa + sb;
      6'h22: r = sa - sb;
      6'h24: r = ua & ub;
      6'h25: r = ua | ub;
      6'h26: r = ua ^ ub;
      6'h27: r = ~(ua | ub);
      6'h03: begin
        if (ub >= 8) r = (sa < 0) ? -1 : 0;
        else begin
          d = 1 << ub;
          m = ((sa % d) + d) % d;
          r = (sa - m) / d;
        end
      end
      6'h02: r = (ub >= 8) ? 0 : ua / (1 << ub);
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  task automatic send_byte(input logic [7:0] d, input int hold);
    @(negedge i_clk);
    i_data      = d;
    i_done_data = 1'b1;
    repeat (hold) @(negedge i_clk);
    i_done_data = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    i_data = 8'hA5;
    i_done_data = 1'b1;
    repeat (2) @(negedge i_clk);
    i_done_data = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_a, o_b, o_op, o_resultado} !== 30'd0) begin
      failures++;
      $display("FAIL reset_regs: a=%h b=%h op=%h res=%h, required all zero", o_a, o_b, o_op, o_resultado);
    end
    checks++;
    if (rx_pulses != 0 || tx_pulses != 0) begin
      failures++;
      $display("FAIL reset_pulses: rx=%0d tx=%0d, required 0/0", rx_pulses, tx_pulses);
    end
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
  endtask

  // Directed table: A, B, opcode byte, expected result.
  logic [7:0] dir_a   [13] = '{8'h04, 8'h06, 8'h02, 8'h7F, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h80, 8'h80, 8'h80, 8'h80, 8'h12};
  logic [7:0] dir_b   [13] = '{8'h02, 8'h03, 8'h05, 8'h01, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h02, 8'h02, 8'h09, 8'h09, 8'h34};
  logic [7:0] dir_op  [13] = '{8'h20, 8'h22, 8'h22, 8'h20, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02, 8'h03, 8'h02, 8'h3F};
  logic [7:0] dir_exp [13] = '{8'h06, 8'h03, 8'hFD, 8'h80, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hE0, 8'h20, 8'hFF, 8'h00, 8'h00};

  task automatic test_directed();
    int rx0, tx0;
    for (int i = 0; i < 13; i++) begin
      rx0 = rx_pulses;
      tx0 = tx_pulses;
      send_byte(dir_a[i], 1);
      send_byte(dir_b[i], 1);
      send_byte(dir_op[i], 1);
      repeat (3) @(negedge i_clk);
      checks++;
      if (o_a !== dir_a[i] || o_b !== dir_b[i] || o_op !== dir_op[i][5:0]) begin
        failures++;
        $display("FAIL dir%0d_operands: a=%h b=%h op=%h, required %h %h %h",
                 i, o_a, o_b, o_op, dir_a[i], dir_b[i], dir_op[i][5:0]);
      end
      checks++;
      if (rx_pulses - rx0 != 1 || tx_pulses - tx0 != 1) begin
        failures++;
        $display("FAIL dir%0d_pulses: rx=%0d tx=%0d, required 1/1", i, rx_pulses - rx0, tx_pulses - tx0);
      end
      checks++;
      if (last_res !== dir_exp[i]) begin
        failures++;
        $display("FAIL dir%0d_result: got %h, required %h", i, last_res, dir_exp[i]);
      end
      checks++;
      if (last_tx_cyc - last_rx_cyc != TX_LAT) begin
        failures++;
        $display("FAIL dir%0d_latency: got %0d, required %0d", i, last_tx_cyc - last_rx_cyc, TX_LAT);
      end
    end
  endtask

  logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

  task automatic test_random();
    logic [7:0] a, b, opb;
    int rx0;
    for (int i = 0; i < 40; i++) begin
      a   = 8'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      opb = 8'($urandom) & 8'hC0;
      opb = opb | {2'b00, (i % 5 == 4) ? 6'($urandom) : valid_ops[$urandom_range(0, 7)]};
      rx0 = rx_pulses;
      send_byte(a, $urandom_range(1, 2));
      send_byte(b, 1);
      send_byte(opb, $urandom_range(1, 3));
      repeat (3) @(negedge i_clk);
      checks++;
      if (rx_pulses - rx0 != 1 || last_res !== model(a, b, opb[5:0])) begin
        failures++;
        $display("FAIL rand%0d: a=%h b=%h op=%h pulses=%0d res=%h, required 1 pulse res=%h",
                 i, a, b, opb[5:0], rx_pulses - rx0, last_res, model(a, b, opb[5:0]));
      end
    end
  endtask

  task automatic test_strobe();
    int rx0;
    rx0 = rx_pulses;
    send_byte(8'h09, 3);
    send_byte(8'h05, 1);
    send_byte(8'h22, 1);
    repeat (3) @(negedge i_clk);
    checks++;
    if (rx_pulses - rx0 != 1 || last_res !== 8'h04 || o_a !== 8'sh09 || o_b !== 8'sh05) begin
      failures++;
      $display("FAIL strobe_hold: pulses=%0d res=%h a=%h b=%h, required 1 04 09 05",
               rx_pulses - rx0, last_res, o_a, o_b);
    end
  endtask

  task automatic test_back_to_back();
    int rx0, tx0;
    logic [7:0] a, b;
    rx0 = rx_pulses;
    tx0 = tx_pulses;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      send_byte(a, 1);
      send_byte(b, 1);
      send_byte(8'h26, 1);
    end
    repeat (3) @(negedge i_clk);
    checks++;
    if (rx_pulses - rx0 != 6 || tx_pulses - tx0 != 6) begin
      failures++;
      $display("FAIL back_to_back_pulses: rx=%0d tx=%0d, required 6/6", rx_pulses - rx0, tx_pulses - tx0);
    end
    checks++;
    if (last_res !== (a ^ b)) begin
      failures++;
      $display("FAIL back_to_back_result: got %h, required %h", last_res, a ^ b);
    end
  endtask

  task automatic test_reset_mid_frame();
    int rx0;
    send_byte(8'h33, 1);
    send_byte(8'h44, 1);
    @(negedge i_clk);
    #2 i_rst = 1'b0;
    #1;
    checks++;
    if (o_a !== 8'sh00 || o_b !== 8'sh00 || o_op !== 6'h00) begin
      failures++;
      $display("FAIL reset_mid_async: a=%h b=%h op=%h, required 00 00 00", o_a, o_b, o_op);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    rx0 = rx_pulses;
    send_byte(8'h04, 1);
    send_byte(8'h02, 1);
    send_byte(8'h20, 1);
    repeat (3) @(negedge i_clk);
    checks++;
    if (rx_pulses - rx0 != 1 || last_res !== 8'h06 || o_a !== 8'sh04 || o_b !== 8'sh02) begin
      failures++;
      $display("FAIL reset_mid_frame: pulses=%0d res=%h a=%h b=%h, required 1 06 04 02",
               rx_pulses - rx0, last_res, o_a, o_b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_strobe();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
